b3_up_counter: RTL and testbench
================================

Name: b3_up_counter

Overview:
- Single-digit base-3 (modulo-3) synchronous up counter with count-enable input and carry-out.
- Holds one ternary digit encoded in 2 bits: 00, 01 and 10.
- Instances cascade into multi-digit base-3 counters: each digit's eu drives the next digit's ei.
- Clocked by the system clock; asynchronous active-low reset.

Parameters:
- RESET_VALUE, 2'b00, digit loaded by reset. Legal values are 0..2; 2'b11 is illegal and must be rejected at elaboration.

Ports:
- clock  input  1  system clock, rising-edge active.
- reset_  input  1  asynchronous active-low reset; forces the digit to RESET_VALUE.
- ei  input  1  enable-in / carry-in; the digit advances on a clock edge only while ei=1.
- eu  output  1  enable-out / carry-out; high when this digit wraps on the next edge.
- q1_q0  output  2  current digit value, q1 is the MSB; legal codes are 00, 01, 10.

Behaviour:
- Interface: one clock, named clock; reset is asynchronous and active-low, named reset_.
- Reset:
  - While reset_=0, q1_q0=RESET_VALUE immediately, independent of clock.
  - eu follows its combinational equation (0 for RESET_VALUE 0 or 1).
  - Counting resumes on the first rising edge after reset_ rises.
- State register: 2 bits, updated on the rising edge of clock.
  - ei=1: 00->01, 01->10, 10->00 (wrap).
  - ei=0: value held.
- Illegal code 11 (reachable only by upset): the next rising edge loads 00 regardless of ei. eu=0 while q1_q0=11.
- eu timing:
  - Combinational (Mealy) output, no register.
  - eu = ei AND (q1_q0==10).
  - No latency: eu follows ei within the same cycle.
  - Asserted exactly in the cycle before the wrap edge.
- Cascading: digit k's eu feeds digit k+1's ei. Chained digits all update on the same edge, giving a correct multi-digit base-3 count. The eu chain is a pure combinational ripple.
- Latency: q1_q0 changes 1 clock after ei is sampled high. No pipeline stages.
- ei toggled mid-cycle: only the value at the rising edge matters for the state; eu tracks ei combinationally.
- Reset asserted mid-count: the digit returns to RESET_VALUE immediately. No partial or pending increment survives.
- Reset release coincident with a clock edge and ei=1: the design does not guarantee the outcome; the bench must keep reset release away from clock edges.

Optional Feature:
- Macro B3_UP_COUNTER_CLEAR_EN.
- When defined:
  - Adds input port clr (1 bit, active high, synchronous).
  - clr=1 at a rising edge loads 00 regardless of ei.
  - clr has priority over ei.
  - eu is forced to 0 while clr=1, so a clear does not propagate a carry.
  - Asynchronous reset_ still dominates clr.
- When undefined:
  - The clr port does not exist.
  - Behaviour is exactly as above.

Test Plan:
- Reset: reset_=0, ei=0 for 1 cycle -> q1_q0=00, eu=0. Then reset_=1, ei=0 for 5 cycles -> q1_q0 stays 00, eu=0.
- Free run: reset_=1, ei=1 for 20 cycles (clock period 10) -> q1_q0 sequence 01,10,00,01,10,00,... with wrap every 3rd edge. eu=1 exactly in cycles where q1_q0=10, else 0.
- Hold: count to 10 with ei=1, then ei=0 for 4 cycles -> q1_q0 stays 10 and eu=0. Raising ei again -> eu=1 at once, and the next edge gives q1_q0=00.
- Async reset mid-count: q1_q0=01, pull reset_ low between clock edges -> q1_q0=00 before the next edge. Release with ei=1 -> 01 after the next edge.
- Cascade: two instances chained (low.eu->high.ei), low.ei=1 for 9 edges -> {high,low} steps 00,01,02,10,11,12,20,21,22,00 (base 3). high.eu=1 only at state 22.
- Clear (with B3_UP_COUNTER_CLEAR_EN): at q1_q0=10 with ei=1, assert clr=1 for one edge -> eu=0 during the clr cycle. q1_q0=00 after the edge, and a downstream digit does not increment.

Source files
------------

// File: rtl/b3_up_counter.sv
// ---------------------------------------------------------------------------
// b3_up_counter -- single base-3 digit up counter with carry chain.
//
// One ternary digit held in two bits (00, 01, 10). The digit advances on
// a rising clock edge while ei is high and wraps 10 -> 00. eu is a
// combinational carry-out, high in the cycle before a wrap, so digits
// chain by connecting eu of digit k to ei of digit k+1.
//
// Parameters:
//   RESET_VALUE  digit loaded by reset_ (0..2; 2'b11 fails elaboration)
//
// Ports:
//   clock   in   system clock, rising edge
//   reset_  in   asynchronous active-low reset, loads RESET_VALUE
//   clr     in   synchronous clear to 00, only with B3_UP_COUNTER_CLEAR_EN
//   ei      in   enable-in / carry-in
//   eu      out  enable-out / carry-out (combinational)
//   q1_q0   out  current digit, q1 is the MSB
//
// Build option:
//   B3_UP_COUNTER_CLEAR_EN  adds the clr port; clr beats ei and masks eu.
//
// digit | meaning
// 00    | zero
// 01    | one
// 10    | two, wraps to 00 on the next enabled edge
// 11    | illegal (upset only), recovers to 00 on the next edge
// ---------------------------------------------------------------------------
module b3_up_counter #(
   parameter logic [1:0] RESET_VALUE = 2'b00
) (
   input  logic       clock,
   input  logic       reset_,
`ifdef B3_UP_COUNTER_CLEAR_EN
   input  logic       clr,
`endif
   input  logic       ei,
   output logic       eu,
   output logic [1:0] q1_q0
);

   generate
      if (RESET_VALUE == 2'b11) begin : g_bad_reset_value
         $error("b3_up_counter: RESET_VALUE 2'b11 is not a legal ternary digit");
      end
   endgenerate

   localparam logic [1:0] DIGIT_0 = 2'b00;
   localparam logic [1:0] DIGIT_1 = 2'b01;
   localparam logic [1:0] DIGIT_2 = 2'b10;

   logic [1:0] digit_q;
   logic [1:0] digit_next;
   logic       clr_int;

`ifdef B3_UP_COUNTER_CLEAR_EN
   assign clr_int = clr;
`else
   assign clr_int = 1'b0;
`endif

   always_comb begin
      digit_next = digit_q;
      unique case (digit_q)
         DIGIT_0: if (ei) digit_next = DIGIT_1;
         DIGIT_1: if (ei) digit_next = DIGIT_2;
         DIGIT_2: if (ei) digit_next = DIGIT_0;
         default: digit_next = DIGIT_0;
      endcase
      if (clr_int) begin
         digit_next = DIGIT_0;
      end
   end

   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         digit_q <= RESET_VALUE;
      end else begin
         digit_q <= digit_next;
      end
   end

   // Mealy carry: no register so a whole chain updates on one edge.
   // A clear must not look like a wrap to the next digit.
   assign eu    = ei & (digit_q == DIGIT_2) & ~clr_int;
   assign q1_q0 = digit_q;

endmodule

// File: tb/tb_b3_up_counter.sv
// ---------------------------------------------------------------------------
// tb_b3_up_counter -- self-checking bench for b3_up_counter.
//
// Two digits are chained (u_low.eu -> u_high.ei) and modelled as a single
// integer counting modulo 9; a third digit with RESET_VALUE 2 runs on its
// own and is modelled modulo 3. Inputs change 1 time unit after a rising
// edge or at the falling edge; outputs are sampled away from rising edges.
// ---------------------------------------------------------------------------
module tb_b3_up_counter;

   logic       clock;
   logic       reset_;
   logic       ei_low;
   logic       ei_rv;
   logic       clr_low;
   logic       clr_high;
   logic       clr_rv;
   logic       eu_low;
   logic       eu_high;
   logic       eu_rv;
   logic [1:0] q_low;
   logic [1:0] q_high;
   logic [1:0] q_rv;

   int n_total;
   int n_pass;

   // Reference model: chained pair as one value 0..8, lone digit 0..2.
   int m_pair;
   int m_rv;

   b3_up_counter #(.RESET_VALUE(2'b00)) u_low (
      .clock  (clock),
      .reset_ (reset_),
`ifdef B3_UP_COUNTER_CLEAR_EN
      .clr    (clr_low),
`endif
      .ei     (ei_low),
      .eu     (eu_low),
      .q1_q0  (q_low)
   );

   b3_up_counter #(.RESET_VALUE(2'b00)) u_high (
      .clock  (clock),
      .reset_ (reset_),
`ifdef B3_UP_COUNTER_CLEAR_EN
      .clr    (clr_high),
`endif
      .ei     (eu_low),
      .eu     (eu_high),
      .q1_q0  (q_high)
   );

   b3_up_counter #(.RESET_VALUE(2'b10)) u_rv2 (
      .clock  (clock),
      .reset_ (reset_),
`ifdef B3_UP_COUNTER_CLEAR_EN
      .clr    (clr_rv),
`endif
      .ei     (ei_rv),
      .eu     (eu_rv),
      .q1_q0  (q_rv)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic logic [1:0] lo_digit(input int v);
      return 2'(v % 3);
   endfunction

   function automatic logic [1:0] hi_digit(input int v);
      return 2'((v / 3) % 3);
   endfunction

   // One rising edge; model advanced from the inputs present at the edge.
   task automatic tick();
      int inc;
      inc = (ei_low === 1'b1) ? 1 : 0;
`ifdef B3_UP_COUNTER_CLEAR_EN
      if (clr_low === 1'b1) begin
         m_pair = (m_pair / 3) * 3;
         inc    = 0;
      end
      if (clr_rv === 1'b1) begin
         m_rv = 0;
      end else
`endif
      m_rv = (m_rv + ((ei_rv === 1'b1) ? 1 : 0)) % 3;
      m_pair = (m_pair + inc) % 9;
      @(posedge clock);
      #1;
   endtask

   // Reset pulse placed between edges, released on a falling edge.
   task automatic do_reset();
      reset_ = 1'b0;
      #1;
      m_pair = 0;
      m_rv   = 2;
      @(negedge clock);
      reset_ = 1'b1;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      ei_low = 1'b0;
      ei_rv  = 1'b0;
      reset_ = 1'b0;
      m_pair = 0;
      m_rv   = 2;
      @(posedge clock);
      #2;
      n_total++;
      if (q_low !== 2'b00) $display("FAIL reset_q_low: got %b want 00", q_low);
      else n_pass++;
      n_total++;
      if (eu_low !== 1'b0) $display("FAIL reset_eu_low: got %b want 0", eu_low);
      else n_pass++;
      n_total++;
      if (q_rv !== 2'b10) $display("FAIL reset_q_rv2: got %b want 10", q_rv);
      else n_pass++;
      ei_rv = 1'b1;
      #1;
      n_total++;
      if (eu_rv !== 1'b1) $display("FAIL reset_eu_rv2_ei1: got %b want 1", eu_rv);
      else n_pass++;
      ei_rv = 1'b0;
      #1;
      n_total++;
      if (eu_rv !== 1'b0) $display("FAIL reset_eu_rv2_ei0: got %b want 0", eu_rv);
      else n_pass++;
      @(negedge clock);
      reset_ = 1'b1;
      @(posedge clock);
      #1;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_total++;
         if (q_low !== 2'b00 || eu_low !== 1'b0)
            $display("FAIL reset_idle[%0d]: got q=%b eu=%b want q=00 eu=0", i, q_low, eu_low);
         else n_pass++;
      end
   endtask

   task automatic test_free_run();
      logic [1:0] exp_q;
      do_reset();
      ei_low = 1'b1;
      for (int i = 0; i < 20; i++) begin
         #1;
         exp_q = 2'(i % 3);
         n_total++;
         if (eu_low !== (exp_q == 2'b10))
            $display("FAIL free_run_eu[%0d]: got %b want %b", i, eu_low, (exp_q == 2'b10));
         else n_pass++;
         tick();
         exp_q = 2'((i + 1) % 3);
         n_total++;
         if (q_low !== exp_q)
            $display("FAIL free_run_q[%0d]: got %b want %b", i, q_low, exp_q);
         else n_pass++;
      end
      ei_low = 1'b0;
   endtask

   task automatic test_hold();
      do_reset();
      ei_low = 1'b1;
      tick();
      tick();
      ei_low = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_total++;
         if (q_low !== 2'b10 || eu_low !== 1'b0)
            $display("FAIL hold[%0d]: got q=%b eu=%b want q=10 eu=0", i, q_low, eu_low);
         else n_pass++;
      end
      ei_low = 1'b1;
      #1;
      n_total++;
      if (eu_low !== 1'b1) $display("FAIL hold_eu_rise: got %b want 1", eu_low);
      else n_pass++;
      tick();
      n_total++;
      if (q_low !== 2'b00) $display("FAIL hold_wrap: got %b want 00", q_low);
      else n_pass++;
      ei_low = 1'b0;
   endtask

   task automatic test_async_reset();
      do_reset();
      ei_low = 1'b1;
      ei_rv  = 1'b1;
      tick();
      ei_rv = 1'b0;
      n_total++;
      if (q_low !== 2'b01 || q_rv !== 2'b00)
         $display("FAIL async_pre: got low=%b rv2=%b want low=01 rv2=00", q_low, q_rv);
      else n_pass++;
      #3;
      reset_ = 1'b0;
      #1;
      m_pair = 0;
      m_rv   = 2;
      n_total++;
      if (q_low !== 2'b00 || q_rv !== 2'b10)
         $display("FAIL async_reset: got low=%b rv2=%b want low=00 rv2=10", q_low, q_rv);
      else n_pass++;
      @(negedge clock);
      reset_ = 1'b1;
      tick();
      n_total++;
      if (q_low !== 2'b01) $display("FAIL async_release: got %b want 01", q_low);
      else n_pass++;
      ei_low = 1'b0;
   endtask

   task automatic test_cascade();
      do_reset();
      ei_low = 1'b1;
      for (int i = 0; i <= 9; i++) begin
         #1;
         n_total++;
         if (q_high !== hi_digit(i) || q_low !== lo_digit(i))
            $display("FAIL cascade_q[%0d]: got %0d%0d want %0d%0d", i, q_high, q_low,
                     hi_digit(i), lo_digit(i));
         else n_pass++;
         n_total++;
         if (eu_high !== ((i % 9) == 8))
            $display("FAIL cascade_eu_high[%0d]: got %b want %b", i, eu_high, ((i % 9) == 8));
         else n_pass++;
         if (i < 9) tick();
      end
      ei_low = 1'b0;
   endtask

`ifdef B3_UP_COUNTER_CLEAR_EN
   task automatic test_clear();
      do_reset();
      ei_low = 1'b1;
      tick();
      tick();
      n_total++;
      if (q_low !== 2'b10) $display("FAIL clear_pre: got %b want 10", q_low);
      else n_pass++;
      clr_low = 1'b1;
      #1;
      n_total++;
      if (eu_low !== 1'b0 || eu_high !== 1'b0)
         $display("FAIL clear_eu: got low=%b high=%b want 0 0", eu_low, eu_high);
      else n_pass++;
      tick();
      clr_low = 1'b0;
      n_total++;
      if (q_low !== 2'b00 || q_high !== 2'b00)
         $display("FAIL clear_q: got high=%b low=%b want 00 00", q_high, q_low);
      else n_pass++;
      ei_low = 1'b0;
   endtask
`endif

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 200; i++) begin
         ei_low = 1'($urandom_range(0, 1));
         ei_rv  = 1'($urandom_range(0, 1));
`ifdef B3_UP_COUNTER_CLEAR_EN
         clr_low = ($urandom_range(0, 7) == 0);
         clr_rv  = ($urandom_range(0, 7) == 0);
`endif
         #1;
         n_total++;
         if (eu_low !== (ei_low && lo_digit(m_pair) == 2'b10 && !clr_low)
             || eu_high !== (ei_low && !clr_low && m_pair == 8)
             || eu_rv !== (ei_rv && m_rv == 2 && !clr_rv))
            $display("FAIL random_eu[%0d]: got low=%b high=%b rv2=%b pair=%0d rv=%0d ei=%b/%b",
                     i, eu_low, eu_high, eu_rv, m_pair, m_rv, ei_low, ei_rv);
         else n_pass++;
         tick();
         n_total++;
         if (q_low !== lo_digit(m_pair) || q_high !== hi_digit(m_pair) || q_rv !== 2'(m_rv))
            $display("FAIL random_q[%0d]: got %0d%0d rv2=%0d want %0d%0d rv2=%0d", i,
                     q_high, q_low, q_rv, hi_digit(m_pair), lo_digit(m_pair), m_rv);
         else n_pass++;
      end
      ei_low  = 1'b0;
      ei_rv   = 1'b0;
      clr_low = 1'b0;
      clr_rv  = 1'b0;
   endtask

   initial begin
      n_total  = 0;
      n_pass   = 0;
      reset_   = 1'b0;
      ei_low   = 1'b0;
      ei_rv    = 1'b0;
      clr_low  = 1'b0;
      clr_high = 1'b0;
      clr_rv   = 1'b0;
      m_pair   = 0;
      m_rv     = 2;
      test_reset();
      test_free_run();
      test_hold();
      test_async_reset();
      test_cascade();
`ifdef B3_UP_COUNTER_CLEAR_EN
      test_clear();
`endif
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
